// File: rtl/pll_clk_monitor.sv
// rtl/pll_clk_monitor.sv - PLL supervisor: reset sequencing, lock watch and frequency window check
// Runs on the reference clock; measures the divide-by-2 toggle of the monitored PLL output.
module pll_clk_monitor #(
  parameter int WINDOW       = 50000,
  parameter int EXP_MIN      = 29850,
  parameter int EXP_MAX      = 30150,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 500000,
  parameter int GOOD_WINDOWS = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pll_locked,
  input  logic        mon_tgl,
  output logic        pll_rst,
  output logic        clk_ok,
  output logic [19:0] meas_count,
  output logic        meas_valid,
  output logic [7:0]  fail_count,
  output logic [1:0]  state
);

  localparam logic [1:0] S_RESET_PLL = 2'd0;
  localparam logic [1:0] S_WAIT_LOCK = 2'd1;
  localparam logic [1:0] S_MEASURE   = 2'd2;
  localparam logic [1:0] S_RUNNING   = 2'd3;

  localparam int WIN_W = $clog2(WINDOW + 1);
  localparam int TO_W  = $clog2(LOCK_TIMEOUT + 1);
  localparam int RC_W  = $clog2(RST_CYCLES + 1);
  localparam int STK_W = $clog2(GOOD_WINDOWS + 1);

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RST_CYCLES - 1);
  localparam logic [STK_W-1:0] STK_LAST = STK_W'(GOOD_WINDOWS - 1);
  localparam logic [19:0]      CNT_MIN  = 20'(EXP_MIN);
  localparam logic [19:0]      CNT_MAX  = 20'(EXP_MAX);

  logic             lock_s1_q, lock_s1_d;
  logic             lock_s2_q, lock_s2_d;
  logic             tgl_s1_q, tgl_s1_d;
  logic             tgl_s2_q, tgl_s2_d;
  logic             tgl_s3_q, tgl_s3_d;
  logic [1:0]       state_q, state_d;
  logic             pll_rst_q, pll_rst_d;
  logic             clk_ok_q, clk_ok_d;
  logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [19:0]      tr_cnt_q, tr_cnt_d;
  logic [STK_W-1:0] streak_q, streak_d;
  logic [19:0]      meas_count_q, meas_count_d;
  logic             meas_valid_q, meas_valid_d;
  logic [7:0]       fail_count_q, fail_count_d;

  logic        lock_s;
  logic        tgl_edge;
  logic        measuring;
  logic        win_end;
  logic [19:0] tr_next;
  logic        in_range;
  logic        fail_evt;

  assign lock_s    = lock_s2_q;
  assign tgl_edge  = tgl_s2_q ^ tgl_s3_q;
  assign measuring = (state_q == S_MEASURE) || (state_q == S_RUNNING);
  assign win_end   = measuring && (win_cnt_q == WIN_LAST);
  // The closing cycle's own transition belongs to the window it closes.
  assign tr_next   = (&tr_cnt_q) ? tr_cnt_q : tr_cnt_q + 20'(tgl_edge);
  assign in_range  = (tr_next >= CNT_MIN) && (tr_next <= CNT_MAX);

  always_comb begin
    lock_s1_d    = pll_locked;
    lock_s2_d    = lock_s1_q;
    tgl_s1_d     = mon_tgl;
    tgl_s2_d     = tgl_s1_q;
    tgl_s3_d     = tgl_s2_q;
    state_d      = state_q;
    pll_rst_d    = pll_rst_q;
    clk_ok_d     = clk_ok_q;
    rst_cnt_d    = rst_cnt_q;
    to_cnt_d     = to_cnt_q;
    win_cnt_d    = '0;
    tr_cnt_d     = '0;
    streak_d     = streak_q;
    meas_count_d = meas_count_q;
    meas_valid_d = 1'b0;
    fail_count_d = fail_count_q;
    fail_evt     = 1'b0;

    // Window and transition counters only run while measuring and restart with no gap.
    if (measuring) begin
      if (win_end) begin
        meas_count_d = tr_next;
        meas_valid_d = 1'b1;
      end else begin
        win_cnt_d = win_cnt_q + 1'b1;
        tr_cnt_d  = tr_next;
      end
    end

    case (state_q)
      S_RESET_PLL: begin
        pll_rst_d = 1'b1;
        clk_ok_d  = 1'b0;
        streak_d  = '0;
        to_cnt_d  = '0;
        if (rst_cnt_q == RC_LAST) begin
          state_d   = S_WAIT_LOCK;
          pll_rst_d = 1'b0;
          rst_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_d  = S_MEASURE;
          to_cnt_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
          fail_evt = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_MEASURE: begin
        if (!lock_s) begin
          fail_evt = 1'b1;
        end else if (win_end) begin
          if (!in_range) begin
            fail_evt = 1'b1;
          end else if (streak_q == STK_LAST) begin
            state_d  = S_RUNNING;
            clk_ok_d = 1'b1;
          end else begin
            streak_d = streak_q + 1'b1;
          end
        end
      end
      default: begin
        if (!lock_s || (win_end && !in_range)) begin
          fail_evt = 1'b1;
        end
      end
    endcase

    // Every retry cause funnels here so coincident causes count once.
    if (fail_evt) begin
      state_d   = S_RESET_PLL;
      pll_rst_d = 1'b1;
      clk_ok_d  = 1'b0;
      rst_cnt_d = '0;
      to_cnt_d  = '0;
      streak_d  = '0;
      if (fail_count_q != 8'hFF) begin
        fail_count_d = fail_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_s1_q    <= 1'b0;
      lock_s2_q    <= 1'b0;
      tgl_s1_q     <= 1'b0;
      tgl_s2_q     <= 1'b0;
      tgl_s3_q     <= 1'b0;
      state_q      <= S_RESET_PLL;
      pll_rst_q    <= 1'b1;
      clk_ok_q     <= 1'b0;
      rst_cnt_q    <= '0;
      to_cnt_q     <= '0;
      win_cnt_q    <= '0;
      tr_cnt_q     <= '0;
      streak_q     <= '0;
      meas_count_q <= '0;
      meas_valid_q <= 1'b0;
      fail_count_q <= '0;
    end else begin
      lock_s1_q    <= lock_s1_d;
      lock_s2_q    <= lock_s2_d;
      tgl_s1_q     <= tgl_s1_d;
      tgl_s2_q     <= tgl_s2_d;
      tgl_s3_q     <= tgl_s3_d;
      state_q      <= state_d;
      pll_rst_q    <= pll_rst_d;
      clk_ok_q     <= clk_ok_d;
      rst_cnt_q    <= rst_cnt_d;
      to_cnt_q     <= to_cnt_d;
      win_cnt_q    <= win_cnt_d;
      tr_cnt_q     <= tr_cnt_d;
      streak_q     <= streak_d;
      meas_count_q <= meas_count_d;
      meas_valid_q <= meas_valid_d;
      fail_count_q <= fail_count_d;
    end
  end

  assign pll_rst    = pll_rst_q;
  assign clk_ok     = clk_ok_q;
  assign meas_count = meas_count_q;
  assign meas_valid = meas_valid_q;
  assign fail_count = fail_count_q;
  assign state      = state_q;

endmodule

// File: tb/tb_pll_clk_monitor.sv
// tb/tb_pll_clk_monitor.sv - self-checking bench for pll_clk_monitor
// Window-level stimulus planner and reference; inputs driven 1 time unit after each rising edge.
module tb_pll_clk_monitor;

  localparam int WIN   = 100;
  localparam int EMIN  = 58;
  localparam int EMAX  = 62;
  localparam int RSTC  = 4;
  localparam int LTO   = 200;
  localparam int GOODW = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pll_locked;
  logic        mon_tgl;
  logic        pll_rst;
  logic        clk_ok;
  logic [19:0] meas_count;
  logic        meas_valid;
  logic [7:0]  fail_count;
  logic [1:0]  state;

  pll_clk_monitor #(
    .WINDOW(WIN), .EXP_MIN(EMIN), .EXP_MAX(EMAX),
    .RST_CYCLES(RSTC), .LOCK_TIMEOUT(LTO), .GOOD_WINDOWS(GOODW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked), .mon_tgl(mon_tgl),
    .pll_rst(pll_rst), .clk_ok(clk_ok), .meas_count(meas_count),
    .meas_valid(meas_valid), .fail_count(fail_count), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n;
    int exp_meas;
    int exp_state;
    int exp_fail;
  } vec_t;

  vec_t vecs[8];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   viol  = 0;
  int   stray;
  int   drop_c;
  int   plan_n[16];
  int   cap_valid[16], cap_count[16], cap_state[16], cap_ok[16], cap_fail[16], cap_rst[16];
  bit   sched[4096];
  int   end_w[4096];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
    if (clk_ok && state != 2'd3) viol++;
  endtask

  task automatic advance(input int target);
    while (cyc < target) tick();
  endtask

  // Reset with the lock input preset, release just after an edge; cyc counts edges since release.
  task automatic start(input logic lock);
    reset_n    = 1'b0;
    pll_locked = lock;
    mon_tgl    = 1'b0;
    drop_c     = -1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc     = 0;
  endtask

  function automatic bit in_rng(input int n);
    return (n >= EMIN) && (n <= EMAX);
  endfunction

  // Plans toggles so window w holds exactly plan_n[w] transitions, then runs to the last window end.
  // Window start: lock is already synced, so measuring begins RSTC+1 edges after any PLL reset.
  // A toggle driven after edge j is seen three edges later, i.e. lands at window slot j+2-start.
  task automatic run_plan(input int nwin);
    int e, last, r, m;
    for (int i = 0; i < 4096; i++) begin
      sched[i] = 1'b0;
      end_w[i] = -1;
    end
    e    = RSTC + 1;
    last = 0;
    for (int w = 0; w < nwin; w++) begin
      r = $urandom_range(0, WIN - 1);
      for (int i = 0; i < plan_n[w]; i++) begin
        m = ((i * WIN) / plan_n[w] + r) % WIN;
        sched[e + m - 2] = 1'b1;
      end
      end_w[e + WIN] = w;
      last = e + WIN;
      e = in_rng(plan_n[w]) ? e + WIN : e + WIN + RSTC + 1;
    end
    stray = 0;
    while (cyc < last) begin
      tick();
      if (cyc == drop_c) pll_locked = 1'b0;
      if (cyc == drop_c + 1) pll_locked = 1'b1;
      if (sched[cyc]) mon_tgl = ~mon_tgl;
      if (end_w[cyc] >= 0) begin
        cap_valid[end_w[cyc]] = int'(meas_valid);
        cap_count[end_w[cyc]] = int'(meas_count);
        cap_state[end_w[cyc]] = int'(state);
        cap_ok[end_w[cyc]]    = int'(clk_ok);
        cap_fail[end_w[cyc]]  = int'(fail_count);
        cap_rst[end_w[cyc]]   = int'(pll_rst);
      end else if (meas_valid) begin
        stray++;
      end
    end
    chk("stray_meas_valid", stray, 0);
  endtask

  // Reference: streak of in-range windows promotes to running; any bad window retries.
  task automatic model_check(input int nwin, input string tag);
    int streak, run, fail, ok;
    streak = 0;
    run    = 0;
    fail   = 0;
    for (int w = 0; w < nwin; w++) begin
      ok = int'(in_rng(plan_n[w]));
      if (ok != 0) begin
        if (run == 0) begin
          streak++;
          if (streak >= GOODW) run = 1;
        end
      end else begin
        if (fail < 255) fail++;
        run    = 0;
        streak = 0;
      end
      chk($sformatf("%s w%0d valid", tag, w), cap_valid[w], 1);
      chk($sformatf("%s w%0d count", tag, w), cap_count[w], plan_n[w]);
      chk($sformatf("%s w%0d state", tag, w), cap_state[w], (ok == 0) ? 0 : ((run != 0) ? 3 : 2));
      chk($sformatf("%s w%0d clk_ok", tag, w), cap_ok[w], run);
      chk($sformatf("%s w%0d fail", tag, w), cap_fail[w], fail);
      chk($sformatf("%s w%0d pll_rst", tag, w), cap_rst[w], (ok == 0) ? 1 : 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, mv;
    vecs[0] = '{60, 60, 2, 0};
    vecs[1] = '{58, 58, 2, 0};
    vecs[2] = '{62, 62, 2, 0};
    vecs[3] = '{57, 57, 0, 1};
    vecs[4] = '{63, 63, 0, 1};
    vecs[5] = '{50, 50, 0, 1};
    vecs[6] = '{0, 0, 0, 1};
    vecs[7] = '{100, 100, 0, 1};

    reset_n    = 1'b0;
    pll_locked = 1'b0;
    mon_tgl    = 1'b0;
    drop_c     = -1;
    tick();
    tick();
    chk("reset pll_rst", int'(pll_rst), 1);
    chk("reset clk_ok", int'(clk_ok), 0);
    chk("reset meas_count", int'(meas_count), 0);
    chk("reset meas_valid", int'(meas_valid), 0);
    chk("reset fail_count", int'(fail_count), 0);
    chk("reset state", int'(state), 0);

    for (int v = 0; v < 8; v++) begin
      start(1'b1);
      plan_n[0] = vecs[v].n;
      run_plan(1);
      chk($sformatf("vec%0d valid", v), cap_valid[0], 1);
      chk($sformatf("vec%0d meas", v), cap_count[0], vecs[v].exp_meas);
      chk($sformatf("vec%0d state", v), cap_state[0], vecs[v].exp_state);
      chk($sformatf("vec%0d fail", v), cap_fail[0], vecs[v].exp_fail);
    end

    // Nominal bring-up, then a one-cycle lock drop while running.
    start(1'b1);
    plan_n[0] = 60; plan_n[1] = 60; plan_n[2] = 60;
    run_plan(3);
    model_check(3, "nominal");
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    chk("drop clk_ok before sync", int'(clk_ok), 1);
    tick();
    chk("drop clk_ok", int'(clk_ok), 0);
    chk("drop state", int'(state), 0);
    chk("drop fail", int'(fail_count), 1);
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      if (pll_rst) hi++;
      tick();
    end
    chk("drop pll_rst cycles", hi, RSTC);
    chk("drop relock state", int'(state), 2);

    start(1'b1);
    plan_n[0] = 50; plan_n[1] = 60; plan_n[2] = 60; plan_n[3] = 60;
    run_plan(4);
    model_check(4, "lowfreq");

    // Lock loss seen in the very cycle that closes a window.
    start(1'b1);
    plan_n[0] = 60; plan_n[1] = 60; plan_n[2] = 60;
    drop_c = 3 * WIN + RSTC + 1 - 3;
    run_plan(3);
    chk("simul valid", cap_valid[2], 1);
    chk("simul count", cap_count[2], 60);
    chk("simul state", cap_state[2], 0);
    chk("simul fail", cap_fail[2], 1);
    mv = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (meas_valid) mv++;
    end
    chk("simul extra valid", mv, 0);
    chk("simul fail once", int'(fail_count), 1);

    for (int it = 0; it < 3; it++) begin
      start(1'b1);
      for (int w = 0; w < 10; w++) plan_n[w] = $urandom_range(55, 65);
      run_plan(10);
      model_check(10, $sformatf("rand%0d", it));
    end

    start(1'b1);
    plan_n[0] = 61;
    run_plan(1);
    advance(cyc + 10);
    chk("pre-reset state", int'(state), 2);
    chk("pre-reset meas", int'(meas_count), 61);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midreset pll_rst", int'(pll_rst), 1);
    chk("midreset clk_ok", int'(clk_ok), 0);
    chk("midreset meas", int'(meas_count), 0);
    chk("midreset valid", int'(meas_valid), 0);
    chk("midreset state", int'(state), 0);

    // Lock never arrives: retries every RSTC+LTO cycles, saturating the retry count.
    start(1'b0);
    for (int i = 1; i <= RSTC; i++) begin
      tick();
      chk($sformatf("pulse cyc%0d", i), int'(pll_rst), (i < RSTC) ? 1 : 0);
    end
    chk("pulse end state", int'(state), 1);
    for (int k = 1; k <= 3; k++) begin
      advance(k * (RSTC + LTO) - 1);
      chk($sformatf("timeout%0d wait state", k), int'(state), 1);
      chk($sformatf("timeout%0d wait fail", k), int'(fail_count), k - 1);
      tick();
      chk($sformatf("timeout%0d state", k), int'(state), 0);
      chk($sformatf("timeout%0d pll_rst", k), int'(pll_rst), 1);
      chk($sformatf("timeout%0d fail", k), int'(fail_count), k);
    end
    advance(255 * (RSTC + LTO));
    chk("sat reach", int'(fail_count), 255);
    advance(260 * (RSTC + LTO));
    chk("sat hold", int'(fail_count), 255);
    chk("sat state", int'(state), 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("sat reset fail", int'(fail_count), 0);

    chk("clk_ok outside running", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pll_clk_monitor.md
Name: pll_clk_monitor

Overview:
- Supervisor for the system PLL. Runs on the 50 MHz reference clock, drives the PLL reset input and consumes its locked output.
- Measures one PLL output clock against the reference. The output is delivered as a divide-by-2 toggle generated by an external flop in the PLL clock domain.
- Reports clock health to downstream reset logic. Automatically re-resets the PLL on lock loss, lock timeout, or frequency out of range.

Parameters:
- WINDOW, 50000, reference cycles per measurement window (1 ms at 50 MHz).
- EXP_MIN, 29850, minimum acceptable mon_tgl transitions per window, inclusive (30 MHz −0.5%).
- EXP_MAX, 30150, maximum acceptable mon_tgl transitions per window, inclusive.
- RST_CYCLES, 16, pll_rst pulse length in clk cycles.
- LOCK_TIMEOUT, 500000, cycles to wait for lock before retrying.
- GOOD_WINDOWS, 2, consecutive in-range windows required before clk_ok is asserted.

Ports:
- clk, in, 1, 50 MHz reference clock.
- reset_n, in, 1, asynchronous active-low reset.
- pll_locked, in, 1, PLL locked; asynchronous, synchronised internally.
- mon_tgl, in, 1, toggles once per monitored-clock rising edge; asynchronous.
- pll_rst, out, 1, active-high PLL reset.
- clk_ok, out, 1, monitored clock locked and in range.
- meas_count, out, 20, transition count of the last completed window.
- meas_valid, out, 1, one-cycle pulse when meas_count updates.
- fail_count, out, 8, number of retries, saturating at 255.
- state, out, 2, FSM state: 0 RESET_PLL, 1 WAIT_LOCK, 2 MEASURE, 3 RUNNING.

Behaviour:
- Reset (reset_n low, asynchronous) forces:
  - pll_rst=1, clk_ok=0, meas_count=0, meas_valid=0, fail_count=0, state=RESET_PLL.
  - All counters and synchroniser flops cleared.
- Input synchronisation:
  - pll_locked passes through a 2-flop synchroniser → lock_s.
  - mon_tgl passes through a 3-flop chain; a transition is s2 XOR s3, counting one per cycle at most.
  - Sampling requirement: the monitored clock must be ≤ 45 MHz so that toggle levels last more than 1 clk.
- Transition counter: 20 bits, saturates at 0xFFFFF.
- Window counter: counts 0..WINDOW−1. On the cycle it reaches WINDOW−1:
  - meas_count ← counter value including any transition in that cycle.
  - meas_valid=1 for that one cycle.
  - Both counters restart from 0 on the next cycle with no gap.
- A window is in range when EXP_MIN ≤ count ≤ EXP_MAX.
- RESET_PLL:
  - pll_rst=1 for exactly RST_CYCLES cycles, then → WAIT_LOCK with pll_rst=0.
  - Window counter and streak are cleared.
- WAIT_LOCK:
  - lock_s=1 → MEASURE, with window and transition counters cleared.
  - LOCK_TIMEOUT cycles without lock → RESET_PLL, fail_count+1.
- MEASURE:
  - Each in-range window increments the streak.
  - When streak reaches GOOD_WINDOWS → RUNNING; clk_ok goes to 1 on the same registered edge as the state change.
  - An out-of-range window → RESET_PLL, fail_count+1.
  - lock_s=0 → RESET_PLL, fail_count+1.
- RUNNING:
  - Measurement continues.
  - An out-of-range window or lock_s=0 → RESET_PLL, fail_count+1, clk_ok=0 on the next edge.
- Simultaneous lock loss and window end:
  - meas_valid still pulses with the count.
  - A single transition to RESET_PLL occurs; fail_count increments once.
- fail_count never wraps; it holds at 255.
- pll_rst and clk_ok are registered outputs. clk_ok is never 1 outside RUNNING.
- Reset asserted mid-operation: immediate return to the reset values. After release, the sequence restarts with a full RST_CYCLES pulse.

Test Plan (sim params: WINDOW=100, EXP_MIN=58, EXP_MAX=62, RST_CYCLES=4, LOCK_TIMEOUT=200, GOOD_WINDOWS=2):
- Nominal bring-up: release reset, raise pll_locked 10 cycles after pll_rst falls, toggle mon_tgl every 5/3 cycles (60 per window) → pll_rst high for 4 cycles, meas_count=60 twice, clk_ok=1 after the second meas_valid, fail_count=0.
- Lock timeout: pll_locked held 0 → pll_rst re-pulses every 204 cycles; fail_count=1,2,3,…; clk_ok stays 0.
- Frequency low: 50 transitions per window with lock held → meas_count=50, RESET_PLL entered, fail_count=1, clk_ok=0; restoring 60 per window recovers RUNNING.
- Boundary counts: windows of 58 and 62 transitions → accepted; 57 or 63 → retry.
- Lock drop in RUNNING: pll_locked low for 1 cycle → clk_ok=0 within 3 cycles (sync + register), pll_rst=1 for 4 cycles, fail_count+1; simultaneous with window end → meas_valid pulses and fail_count increments exactly once.
- Saturation and reset: force 260 timeouts → fail_count=255; assert reset_n mid-MEASURE → all outputs return to reset values immediately.
